// File: rtl/bcd_display_scan_if.sv
// Bus between the timekeeper side and the 6-digit multiplexed display scanner.
// The master drives time digits and display controls; the slave drives the display pins.
interface bcd_display_scan_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic [3:0] S_in1;
  logic [3:0] S_in0;
  logic       alarm_in;
  logic       blank_lz;
  logic [5:0] an_out;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       frame_done;

  modport master (
    output H_in1, H_in0, M_in1, M_in0, S_in1, S_in0, alarm_in, blank_lz,
    input  an_out, seg_out, dp_out, frame_done
  );

  modport slave (
    input  H_in1, H_in0, M_in1, M_in0, S_in1, S_in0, alarm_in, blank_lz,
    output an_out, seg_out, dp_out, frame_done
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Multiplexed 6-digit 7-segment scanner (HH.MM.SS) with per-frame time snapshot,
// leading-zero blanking of hours tens and whole-display blink while the alarm is active.
module bcd_display_scan #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                clk,
  input  logic                reset,
  bcd_display_scan_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  logic [PW-1:0]     pre_q, pre_d;
  logic [2:0]        idx_q, idx_d;
  logic [5:0][3:0]   shadow_q, shadow_d;
  logic [FW-1:0]     frm_q, frm_d;
  logic              phase_q, phase_d;
  logic [5:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              fd_q, fd_d;

  logic              tick;
  logic              snap;
  logic [3:0]        cur;
  logic              blink_off;
  logic              lz_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      frm_q    <= '0;
      phase_q  <= 1'b0;
      an_q     <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frm_q    <= frm_d;
      phase_q  <= phase_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end

  // Scan timing: prescaler, digit index and the end-of-frame snapshot.
  always_comb begin
    tick     = (pre_q == PRE_MAX);
    snap     = tick && (idx_q == 3'd5);
    pre_d    = tick ? '0 : pre_q + PW'(1);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    shadow_d = shadow_q;
    if (snap) begin
      shadow_d = {2'b00, bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0, bus.S_in1, bus.S_in0};
    end
  end

  // Blink counter only runs while the alarm is asserted; otherwise it is parked at zero.
  always_comb begin
    frm_d   = frm_q;
    phase_d = phase_q;
    if (!bus.alarm_in) begin
      frm_d   = '0;
      phase_d = 1'b0;
    end else if (snap) begin
      if (frm_q == FRM_MAX) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
  end

  // Output stage: gating uses the live alarm so dropping it un-blanks on the next edge.
  always_comb begin
    case (idx_q)
      3'd0:    cur = shadow_q[0];
      3'd1:    cur = shadow_q[1];
      3'd2:    cur = shadow_q[2];
      3'd3:    cur = shadow_q[3];
      3'd4:    cur = shadow_q[4];
      3'd5:    cur = shadow_q[5];
      default: cur = 4'd0;
    endcase
    blink_off = bus.alarm_in && phase_q;
    lz_off    = (idx_q == 3'd5) && bus.blank_lz && (cur == 4'd0);
    an_d      = 6'b000001 << idx_q;
    seg_d     = (blink_off || lz_off) ? 7'b0000000 : decode7(cur);
    dp_d      = !blink_off && ((idx_q == 3'd2) || (idx_q == 3'd4));
    fd_d      = snap;
  end

  assign bus.an_out     = an_q;
  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: frame-by-frame vectors plus reset, blink and
// mid-frame corner sequences, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_bcd_display_scan;

  typedef struct packed {
    logic [1:0]      h1;
    logic [3:0]      h0;
    logic [3:0]      m1;
    logic [3:0]      m0;
    logic [3:0]      s1;
    logic [3:0]      s0;
    logic            lz;
    logic [5:0][6:0] seg;
  } rec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  rec_t vec [7];
  rec_t zero_rec;

  bcd_display_scan_if bus ();

  bcd_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic rec_t mk(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                              input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0,
                              input logic lz, input logic [6:0] g5, input logic [6:0] g4,
                              input logic [6:0] g3, input logic [6:0] g2, input logic [6:0] g1,
                              input logic [6:0] g0);
    rec_t r;
    r.h1 = h1; r.h0 = h0; r.m1 = m1; r.m0 = m0; r.s1 = s1; r.s0 = s0;
    r.lz = lz;
    r.seg = {g5, g4, g3, g2, g1, g0};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_digits(input rec_t r);
    bus.H_in1 = r.h1; bus.H_in0 = r.h0;
    bus.M_in1 = r.m1; bus.M_in0 = r.m0;
    bus.S_in1 = r.s1; bus.S_in0 = r.s0;
  endtask

  // One 24-cycle frame starting at digit 0; digits of nxt go in mid-frame, blank_lz at frame end.
  task automatic capture_frame(input string tag, input rec_t exp, input bit blank, input rec_t nxt);
    for (int c = 0; c < 24; c++) begin
      int k;
      @(posedge clk);
      @(negedge clk);
      k = c / 4;
      chk($sformatf("%s an c%0d", tag, c), 32'(bus.an_out), 32'(6'b000001 << k));
      chk($sformatf("%s frame_done c%0d", tag, c), 32'(bus.frame_done), (c == 23) ? 32'd1 : 32'd0);
      if (c % 4 == 1) begin
        chk($sformatf("%s seg d%0d", tag, k), 32'(bus.seg_out), blank ? 32'd0 : 32'(exp.seg[k]));
        chk($sformatf("%s dp d%0d", tag, k), 32'(bus.dp_out),
            (!blank && (k == 2 || k == 4)) ? 32'd1 : 32'd0);
      end
      if (c == 6) set_digits(nxt);
      if (c == 23) bus.blank_lz = nxt.lz;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    zero_rec = mk(2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0,
                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
    vec[0] = mk(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b0,
                7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101);
    vec[1] = mk(2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9, 1'b0,
                7'b1011011, 7'b1001111, 7'b1101101, 7'b1101111, 7'b1101101, 7'b1101111);
    vec[2] = mk(2'd0, 4'd7, 4'd0, 4'd8, 4'd0, 4'd0, 1'b1,
                7'b0000000, 7'b0000111, 7'b0111111, 7'b1111111, 7'b0111111, 7'b0111111);
    vec[3] = mk(2'd0, 4'd7, 4'd0, 4'd8, 4'd0, 4'd0, 1'b0,
                7'b0111111, 7'b0000111, 7'b0111111, 7'b1111111, 7'b0111111, 7'b0111111);
    vec[4] = mk(2'd1, 4'd0, 4'd2, 4'hC, 4'd4, 4'd1, 1'b1,
                7'b0000110, 7'b0111111, 7'b1011011, 7'b1000000, 7'b1100110, 7'b0000110);
    vec[5] = mk(2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1,
                7'b0000000, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
    vec[6] = mk(2'd1, 4'd9, 4'hA, 4'd3, 4'd7, 4'hF, 1'b0,
                7'b0000110, 7'b1101111, 7'b1000000, 7'b1001111, 7'b0000111, 7'b1000000);

    reset = 1'b1;
    set_digits(vec[0]);
    bus.blank_lz = vec[0].lz;
    bus.alarm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset an", 32'(bus.an_out), 32'd0);
    chk("reset seg", 32'(bus.seg_out), 32'd0);
    chk("reset dp", 32'(bus.dp_out), 32'd0);
    chk("reset frame_done", 32'(bus.frame_done), 32'd0);
    reset = 1'b0;

    // First frame after reset shows the zeroed shadow even though 12:34:56 is applied.
    capture_frame("frame1", zero_rec, 1'b0, vec[0]);

    // Each frame shows vec[i]; vec[i+1] is applied mid-frame and must not appear until next frame.
    for (int i = 0; i < 7; i++) begin
      capture_frame($sformatf("vec%0d", i), vec[i], 1'b0, vec[(i < 6) ? i + 1 : 6]);
    end

    // Blink: two visible frames, two blank frames, two visible frames.
    bus.alarm_in = 1'b1;
    capture_frame("blinkA0", vec[6], 1'b0, vec[6]);
    capture_frame("blinkA1", vec[6], 1'b0, vec[6]);
    capture_frame("blinkB0", vec[6], 1'b1, vec[6]);
    capture_frame("blinkB1", vec[6], 1'b1, vec[6]);
    capture_frame("blinkC0", vec[6], 1'b0, vec[6]);
    capture_frame("blinkC1", vec[6], 1'b0, vec[6]);

    // Drop the alarm during a blank frame; segments return on the very next edge.
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 0) chk("blank frame seg d0", 32'(bus.seg_out), 32'd0);
      if (c == 4) begin
        chk("blank frame seg d1", 32'(bus.seg_out), 32'd0);
        chk("blank frame an d1", 32'(bus.an_out), 32'b000010);
        bus.alarm_in = 1'b0;
      end
      if (c == 5) chk("unblink seg d1", 32'(bus.seg_out), 32'(vec[6].seg[1]));
      if (c == 9) chk("unblink dp d2", 32'(bus.dp_out), 32'd1);
    end

    // Asynchronous reset mid-digit clears outputs without waiting for a clock edge.
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset an", 32'(bus.an_out), 32'd0);
    chk("midreset seg", 32'(bus.seg_out), 32'd0);
    chk("midreset dp", 32'(bus.dp_out), 32'd0);
    chk("midreset frame_done", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    capture_frame("postreset", zero_rec, 1'b0, vec[6]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Consumer of the timekeeper's six BCD time digits and its Alarm flag; drives a 6-digit multiplexed 7-segment display (HH.MM.SS).
- Scans one digit at a time, decodes BCD to segments and inserts separator dots.
- Latches all six digits once per frame so a display frame never shows a partially updated time.
- Blinks the whole display while the alarm is active.

Parameters:
- SCAN_DIV, 4, clk cycles each digit is held. Legal range is 1 or more.
- BLINK_FRAMES, 8, frames per blink half-period.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- H_in1  input  2  hours tens, BCD; zero-extended to 4 bits internally
- H_in0  input  4  hours units, BCD
- M_in1  input  4  minutes tens, BCD
- M_in0  input  4  minutes units, BCD
- S_in1  input  4  seconds tens, BCD
- S_in0  input  4  seconds units, BCD
- alarm_in  input  1  alarm active; enables blinking
- blank_lz  input  1  blank a leading zero in hours tens
- an_out  output  6  one-hot digit enable; bit i = digit i
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active high
- dp_out  output  1  decimal point for the current digit
- frame_done  output  1  one-cycle pulse at each snapshot

Behaviour:
- Digit index mapping: 0=S_in0, 1=S_in1, 2=M_in0, 3=M_in1, 4=H_in0, 5=H_in1.
- Reset, asynchronous:
  - an_out, seg_out, dp_out, frame_done all 0.
  - Prescaler, digit index, frame counter and blink_phase all 0.
  - Shadow digit registers all 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - tick = (prescaler == SCAN_DIV-1); the prescaler wraps to 0 on tick.
  - SCAN_DIV=1 means tick on every cycle.
- Digit index: increments on tick and wraps 5→0. Frame length is 6*SCAN_DIV cycles.
- Snapshot:
  - On the edge where tick && index==5, the shadow registers load all six inputs.
  - frame_done is registered high for that one cycle only.
  - Inputs are never sampled at any other time, so the first frame after reset displays 00:00:00.
- Outputs are registered, one cycle of latency from index and shadow:
  - an_out = 1<<index.
  - seg_out = decode(shadow[index]).
  - dp_out = 1 when index is 2 or 4; 0 otherwise.
- Decode (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Codes 10–15 decode to 1000000 (dash) as an error indicator.
- Leading zero: when index==5, blank_lz=1 and shadow hours tens == 0, seg_out=0. an_out still asserts.
- Blink:
  - While alarm_in=0: frame counter and blink_phase are held at 0.
  - While alarm_in=1: the frame counter increments at each snapshot edge and wraps at BLINK_FRAMES-1; each wrap toggles blink_phase.
  - When blink_phase=1: seg_out=0 and dp_out=0; an_out keeps scanning.
  - Rising alarm_in therefore gives BLINK_FRAMES visible frames first.
  - Falling alarm_in restores a visible display on the next registered output.
- blank_lz and alarm_in are sampled every cycle; they are not snapshotted.
- Reset mid-frame: outputs go to 0 immediately. After release, scanning restarts at index 0 with zero shadow.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2):
- Release reset with inputs 12:34:56 held.
  - Frame 1 shows 000000; frame_done pulses at cycle 24.
  - Frame 2, digit 0: an=000001, seg=1111101.
  - Frame 2, digit 5: an=100000, seg=0000110.
  - Frame 2, digit 4 (2): dp=1.
- Change inputs to 23:59:59 at cycle 30, mid-frame 2 → frame 2 still shows 123456; frame 3 shows 235959.
- H=07, blank_lz=1 → digit 5 seg=0000000, an=100000; digit 4 seg=0000111. With blank_lz=0, digit 5 seg=0111111.
- M_in0=4'hC → digit 2 seg=1000000 with dp=1; the other digits are unaffected.
- alarm_in=1 held:
  - 2 frames visible, 2 frames with seg=0 and dp=0 while an still cycles, repeating.
  - Dropping alarm_in during a blank frame makes segments reappear within 1 cycle.
- Assert reset at cycle 50, mid-digit → all outputs 0 that cycle. After release, the first an_out=000001 and the first frame shows 000000.
